// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// register offsets, CTRL/STAT bit positions and the prescaler mask helper.
package timer_pkg;

  typedef enum logic [1:0] {
    TMR_CTRL = 2'd0,
    TMR_LOAD = 2'd1,
    TMR_CNT  = 2'd2,
    TMR_STAT = 2'd3
  } tmr_reg_e;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_PER    = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_PS_LSB = 4;
  localparam int CTRL_PS_MSB = 6;

  // STAT bit positions
  localparam int STAT_TF  = 0;
  localparam int STAT_RUN = 1;

  // Low PS bits of the prescaler that must all be 1 for a tick (PS=0 -> 0).
  function automatic logic [6:0] ps_mask(input logic [2:0] ps);
    logic [7:0] full;
    full = (8'd1 << ps) - 8'd1;
    return full[6:0];
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 7-bit divider. Produces a one-cycle tick every 2^ps enabled
// cycles; restart forces the count back to zero so the first tick after it
// lands 2^ps cycles later. The tick is combinational from the current count
// so the parent can decide how it interacts with simultaneous bus writes.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       restart,
  input  logic [2:0] ps,
  output logic       tick
);

  logic [6:0] pre_q;
  logic [6:0] pre_d;
  logic [6:0] mask;

  // Tick when the selected low bits are about to wrap; advance only while enabled.
  always_comb begin
    mask  = ps_mask(ps);
    tick  = en && ((pre_q & mask) == mask);
    pre_d = pre_q;
    if (restart) begin
      pre_d = 7'd0;
    end else if (en) begin
      pre_d = pre_q + 7'd1;
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= 7'd0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/timer_periph.sv
// 8-bit down-counting timer responder on the MiniRISC data bus. Decodes a
// 4-register window at BASEADDR, counts LOAD..0 at the prescaled rate, sets
// TF on underflow (reloading in periodic mode, stopping in one-shot mode)
// and raises irq = TF & IE. Read data is zero unless this block is read, so
// it can be OR-ed with other responders.
module timer_periph
  import timer_pkg::*;
#(
  parameter logic [7:0] BASEADDR = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mst2slv_addr,
  input  logic       mst2slv_wr,
  input  logic       mst2slv_rd,
  input  logic [7:0] mst2slv_data,
  output logic [7:0] slv2mst_data,
  output logic       irq
);

  logic       en_q,   en_d;
  logic       per_q,  per_d;
  logic       ie_q,   ie_d;
  logic [2:0] ps_q,   ps_d;
  logic [7:0] load_q, load_d;
  logic [7:0] cnt_q,  cnt_d;
  logic       tf_q,   tf_d;

  logic       sel;
  tmr_reg_e   reg_sel;
  logic       wr_ctrl, wr_load, wr_stat;
  logic       tick, tick_eff, pre_restart;
  logic       tf_set, en_clr;
  logic [7:0] rdata;

  // Address decode and per-register write strobes.
  always_comb begin
    sel     = (mst2slv_addr[7:2] == BASEADDR[7:2]);
    reg_sel = tmr_reg_e'(mst2slv_addr[1:0]);
    wr_ctrl = mst2slv_wr && sel && (reg_sel == TMR_CTRL);
    wr_load = mst2slv_wr && sel && (reg_sel == TMR_LOAD);
    wr_stat = mst2slv_wr && sel && (reg_sel == TMR_STAT);
    // Software turning the timer off in the tick cycle cancels that tick.
    tick_eff    = tick && !(wr_ctrl && !mst2slv_data[CTRL_EN]);
    // A new LOAD value or an EN rise starts a fresh prescaler period.
    pre_restart = wr_load || (wr_ctrl && mst2slv_data[CTRL_EN] && !en_q);
  end

  timer_prescaler u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en_q),
    .restart (pre_restart),
    .ps      (ps_q),
    .tick    (tick)
  );

  // Count/underflow effects first, then bus writes override where they overlap.
  always_comb begin
    en_d   = en_q;
    per_d  = per_q;
    ie_d   = ie_q;
    ps_d   = ps_q;
    load_d = load_q;
    cnt_d  = cnt_q;
    tf_set = 1'b0;
    en_clr = 1'b0;

    if (tick_eff) begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        tf_set = 1'b1;
        if (per_q) begin
          cnt_d = load_q;
        end else begin
          en_clr = 1'b1;
        end
      end
    end
    if (en_clr) begin
      en_d = 1'b0;
    end

    if (wr_ctrl) begin
      en_d  = mst2slv_data[CTRL_EN];
      per_d = mst2slv_data[CTRL_PER];
      ie_d  = mst2slv_data[CTRL_IE];
      ps_d  = mst2slv_data[CTRL_PS_MSB:CTRL_PS_LSB];
    end
    if (wr_load) begin
      load_d = mst2slv_data;
      cnt_d  = mst2slv_data;
    end

    // Underflow set has priority over a write-1 clear in the same cycle.
    tf_d = (tf_q && !(wr_stat && mst2slv_data[STAT_TF])) || tf_set;
  end

  // Register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      per_q  <= 1'b0;
      ie_q   <= 1'b0;
      ps_q   <= 3'd0;
      load_q <= 8'd0;
      cnt_q  <= 8'd0;
      tf_q   <= 1'b0;
    end else begin
      en_q   <= en_d;
      per_q  <= per_d;
      ie_q   <= ie_d;
      ps_q   <= ps_d;
      load_q <= load_d;
      cnt_q  <= cnt_d;
      tf_q   <= tf_d;
    end
  end

  // Zero-latency read mux; drives zero when not selected for a read.
  always_comb begin
    rdata = 8'h00;
    if (sel && mst2slv_rd) begin
      case (reg_sel)
        TMR_CTRL: rdata = {1'b0, ps_q, 1'b0, ie_q, per_q, en_q};
        TMR_LOAD: rdata = load_q;
        TMR_CNT:  rdata = cnt_q;
        TMR_STAT: rdata = {6'd0, en_q, tf_q};
        default:  rdata = 8'h00;
      endcase
    end
  end

  assign slv2mst_data = rdata;
  assign irq          = tf_q & ie_q;

endmodule

// File: tb/tb_timer_periph.sv
// Directed bench for timer_periph: bus decode, periodic and one-shot runs,
// simultaneous-event priorities, IE gating and asynchronous reset.
module tb_timer_periph;

  logic       clk;
  logic       rst_n;
  logic [7:0] mst2slv_addr;
  logic       mst2slv_wr;
  logic       mst2slv_rd;
  logic [7:0] mst2slv_data;
  logic [7:0] slv2mst_data;
  logic       irq;

  int n_vec;
  int n_err;

  timer_periph #(.BASEADDR(8'h80)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mst2slv_addr (mst2slv_addr),
    .mst2slv_wr   (mst2slv_wr),
    .mst2slv_rd   (mst2slv_rd),
    .mst2slv_data (mst2slv_data),
    .slv2mst_data (slv2mst_data),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge.
  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    mst2slv_addr = a;
    mst2slv_data = d;
    mst2slv_wr   = 1'b1;
    @(negedge clk);
    mst2slv_wr   = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
    mst2slv_addr = a;
    mst2slv_rd   = 1'b1;
    #1;
    chk(tag, slv2mst_data, exp);
    @(negedge clk);
    mst2slv_rd   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n        = 1'b0;
    mst2slv_addr = 8'h00;
    mst2slv_wr   = 1'b0;
    mst2slv_rd   = 1'b0;
    mst2slv_data = 8'h00;
    idle(2);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    rst_n = 1'b1;
    rd_chk(8'h80, 8'h00, "rst_ctrl");
    rd_chk(8'h83, 8'h00, "rst_stat");

    // Bus decode
    bus_wr(8'h81, 8'h5A);
    rd_chk(8'h81, 8'h5A, "dec_load");
    rd_chk(8'h82, 8'h5A, "dec_cnt");
    bus_wr(8'h84, 8'h07);
    bus_wr(8'h85, 8'h33);
    rd_chk(8'h80, 8'h00, "dec_nosel_ctrl");
    rd_chk(8'h81, 8'h5A, "dec_nosel_load");
    rd_chk(8'h40, 8'h00, "dec_rd_other");
    rd_chk(8'h85, 8'h00, "dec_rd_84win");
    bus_wr(8'h82, 8'h11);
    rd_chk(8'h82, 8'h5A, "cnt_ro");

    // Periodic run: LOAD=3, PS=0 -> TF every 4 cycles
    bus_wr(8'h81, 8'h03);
    bus_wr(8'h80, 8'h07);
    for (int k = 0; k < 4; k++) begin
      chk("per_irq_lo", {7'd0, irq}, 8'h00);
      rd_chk(8'h83, 8'h02, "per_stat_run");
    end
    chk("per_irq_hi", {7'd0, irq}, 8'h01);
    rd_chk(8'h83, 8'h03, "per_stat_tf");
    bus_wr(8'h83, 8'h01);
    chk("per_clr_irq", {7'd0, irq}, 8'h00);
    rd_chk(8'h83, 8'h02, "per_clr_stat");
    rd_chk(8'h83, 8'h02, "per_stat_e7");
    chk("per_irq_again", {7'd0, irq}, 8'h01);
    rd_chk(8'h83, 8'h03, "per_stat_e8");

    // STAT clear coinciding with underflow: set wins
    idle(2);
    bus_wr(8'h83, 8'h01);
    rd_chk(8'h83, 8'h03, "tf_set_wins");

    // LOAD write coinciding with a tick: no decrement
    bus_wr(8'h81, 8'h10);
    rd_chk(8'h82, 8'h10, "load_vs_tick");
    rd_chk(8'h82, 8'h0F, "cnt_after_load");

    // EN=0 write in a tick cycle: tick has no effect
    bus_wr(8'h80, 8'h00);
    rd_chk(8'h82, 8'h0E, "en_off_no_tick");
    bus_wr(8'h83, 8'h01);
    rd_chk(8'h83, 8'h00, "stat_cleared");

    // One-shot with PS=2: LOAD=2 -> TF after 12 cycles, then stops
    bus_wr(8'h81, 8'h02);
    bus_wr(8'h80, 8'h21);
    idle(11);
    rd_chk(8'h83, 8'h02, "os_before");
    rd_chk(8'h83, 8'h01, "os_tf");
    rd_chk(8'h80, 8'h20, "os_en_clr");
    rd_chk(8'h82, 8'h00, "os_cnt0");
    idle(10);
    rd_chk(8'h83, 8'h01, "os_stopped");
    rd_chk(8'h82, 8'h00, "os_cnt_hold");

    // IE gating
    chk("ie_off_irq", {7'd0, irq}, 8'h00);
    bus_wr(8'h80, 8'h04);
    chk("ie_on_irq", {7'd0, irq}, 8'h01);

    // Simultaneous read and write return the pre-edge value
    mst2slv_addr = 8'h81;
    mst2slv_data = 8'h77;
    mst2slv_wr   = 1'b1;
    mst2slv_rd   = 1'b1;
    #1;
    chk("rw_old", slv2mst_data, 8'h02);
    @(negedge clk);
    mst2slv_wr = 1'b0;
    mst2slv_rd = 1'b0;
    rd_chk(8'h81, 8'h77, "rw_new");

    // Asynchronous reset mid-count
    bus_wr(8'h80, 8'h07);
    idle(3);
    #2;
    rst_n        = 1'b0;
    mst2slv_addr = 8'h81;
    mst2slv_rd   = 1'b1;
    #1;
    chk("arst_irq", {7'd0, irq}, 8'h00);
    chk("arst_rdata", slv2mst_data, 8'h00);
    @(negedge clk);
    mst2slv_rd = 1'b0;
    rst_n      = 1'b1;
    rd_chk(8'h80, 8'h00, "arst_ctrl");
    rd_chk(8'h81, 8'h00, "arst_load");
    rd_chk(8'h82, 8'h00, "arst_cnt");
    rd_chk(8'h83, 8'h00, "arst_stat");
    idle(5);
    rd_chk(8'h82, 8'h00, "arst_no_count");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_periph.md
# timer_periph

Memory-mapped 8-bit down-counting timer that sits as a responder on the MiniRISC data memory bus, opposite the CPU datapath's address/write-data/read-data port. It decodes a 4-byte register window, accepts CPU writes, returns register contents on reads, and raises a level interrupt request on underflow. Its read-data output follows the bus's wired-OR rule: it drives zero whenever it is not addressed by a read.

## Interface
- BASEADDR, 8'h80, base of the 4-register window; bits [1:0] must be 0.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mst2slv_addr  input  8  data memory address from the CPU.
- mst2slv_wr  input  1  write strobe, one cycle per write.
- mst2slv_rd  input  1  read strobe, one cycle per read.
- mst2slv_data  input  8  write data from the CPU.
- slv2mst_data  output  8  read data; 8'h00 unless selected and mst2slv_rd=1.
- irq  output  1  interrupt request, level, active-high.

## Operation
- Select: sel = (mst2slv_addr[7:2] == BASEADDR[7:2]); register = addr[1:0].
- Registers:
  - 0 CTRL (R/W): [0] EN, [1] PER (1 periodic, 0 one-shot), [2] IE, [6:4] PS, [7] and [3] read 0.
  - 1 LOAD (R/W): reload value.
  - 2 CNT (RO): current count; writes ignored.
  - 3 STAT: [0] TF underflow flag, write 1 clears, write 0 no effect; [1] RUN = EN (RO); others read 0.
- Prescaler: 7-bit counter; tick when EN=1 and prescaler[PS-1:0] wraps to 0, i.e. one tick every 2^PS cycles (PS=0: every cycle).
- On tick:
  - CNT != 0: CNT <= CNT-1.
  - CNT == 0: TF <= 1; if PER, CNT <= LOAD; else CNT stays 0 and EN <= 0.
- LOAD write: LOAD <= data and CNT <= data in the same edge; the prescaler restarts at 0.
- CTRL write with EN rising 0->1: the prescaler restarts at 0; CNT is unchanged.
- EN=0: the prescaler and CNT hold their values.
- irq = TF & IE, driven directly from registers (glitch-free).
- Read mux: combinational from the current register values. Reads have no side effects.
- Write strobes with sel=0 are ignored. mst2slv_wr and mst2slv_rd high together: the write takes effect, and the read returns the pre-edge value.

## Timing
- Reset values:
  - CTRL=0, LOAD=0, CNT=0, TF=0, prescaler=0.
  - irq=0, slv2mst_data=0.
- Writes take effect at the rising edge where mst2slv_wr=1. A read issued in the next cycle returns the new value.
- Read latency is 0: slv2mst_data is valid in the same cycle as mst2slv_rd.
- Period, PER=1: LOAD=L, PS=p gives TF every (L+1)*2^p cycles. With PS=0, TF sets on the edge where the tick finds CNT=0.
- First tick after a LOAD write or EN rise comes 2^p cycles later (p=0: the next edge).
- Simultaneous events:
  - Underflow tick and STAT write-1 to TF in the same cycle: set wins, TF=1.
  - Tick and LOAD write in the same cycle: the LOAD write wins; CNT=new value, no decrement. TF still sets if the tick found CNT=0.
  - CTRL write EN=0 in the same cycle as a tick: no tick effect.
- Reset asserted mid-count: all state clears immediately (asynchronous); counting resumes only after software sets EN again.
- CNT wraps only via reload; it never decrements below 0.

## Structure
- Package timer_pkg holds:
  - register offsets: TMR_CTRL=2'd0, TMR_LOAD=2'd1, TMR_CNT=2'd2, TMR_STAT=2'd3;
  - CTRL bit positions: EN=0, PER=1, IE=2, PS=6:4;
  - STAT bit positions: TF=0, RUN=1.
- Sub-module timer_prescaler (clk, rst_n, en, restart, ps[2:0] -> tick) isolates the divider. The top holds bus decode, registers and count logic.

## Test plan
- Reset: assert rst_n=0 mid-operation -> all registers read 0, irq=0, slv2mst_data=0 while rst_n=0.
- Bus decode, BASEADDR=8'h80:
  - write 8'h5A to 8'h81 -> read of 8'h81 returns 8'h5A and 8'h82 returns 8'h5A;
  - write to 8'h84 -> no change;
  - read of 8'h40 -> 8'h00.
- Periodic run: LOAD=3, CTRL=8'h07 (EN, PER, IE, PS=0) -> TF/irq rise 4 cycles after the CTRL write and every 4 cycles after. STAT write 8'h01 clears irq in the next cycle.
- One-shot with prescale: LOAD=2, CTRL=8'h21 (EN, PS=2) -> TF sets after 12 cycles, EN/RUN read 0, CNT holds 0, no further TF.
- Simultaneous events:
  - at an underflow tick, write STAT=8'h01 -> TF=1 after the edge;
  - LOAD write coinciding with a tick -> CNT equals the written value.
- IE gating: TF=1 with IE=0 -> irq=0; setting IE=1 -> irq=1 in the next cycle without a new underflow.
